// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration-time helpers for the multi-cycle serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int num_slices(input int width, input int bpc);
    return width / bpc;
  endfunction

  function automatic int count_width(input int width, input int bpc);
    return $clog2((width / bpc) + 1);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational BITS-wide ripple full adder; also exposes the carry into its MSB.
module adder_slice #(
  parameter int BITS = 1
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin,
  output logic [BITS-1:0] s,
  output logic            cout,
  output logic            cmsb
);

  logic [BITS:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < BITS; gi++) begin : g_bit
    assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
  end

  assign cout = c[BITS];
  assign cmsb = c[BITS-1];

endmodule

// File: rtl/serial_adder.sv
// Handshaked serial adder/subtractor, BITS_PER_CYC bits per CALC cycle.
// Optional build macro SERIAL_ADDER_SAT_EN clamps sum on unsigned carry/borrow.
import serial_adder_pkg::*;

module serial_adder #(
  parameter int WIDTH        = 8,
  parameter int BITS_PER_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = num_slices(WIDTH, BITS_PER_CYC);
  localparam int CW = count_width(WIDTH, BITS_PER_CYC);

  if (WIDTH < 2 || WIDTH > 32 || BITS_PER_CYC < 1 || (WIDTH % BITS_PER_CYC) != 0) begin : g_param_check
    $error("serial_adder: WIDTH must be 2..32 and divisible by BITS_PER_CYC");
  end

  state_t                  state_reg;
  logic [WIDTH-1:0]        a_reg;
  logic [WIDTH-1:0]        b_reg;
  logic [WIDTH-1:0]        res_reg;
  logic                    carry_reg;
  logic [CW-1:0]           count_reg;

  logic [BITS_PER_CYC-1:0] slice_s;
  logic                    slice_cout;
  logic                    slice_cmsb;
  logic [WIDTH-1:0]        res_shift;
  logic [WIDTH-1:0]        final_sum;
  logic                    last_slice;

  adder_slice #(.BITS(BITS_PER_CYC)) u_slice (
    .a    (a_reg[BITS_PER_CYC-1:0]),
    .b    (b_reg[BITS_PER_CYC-1:0]),
    .cin  (carry_reg),
    .s    (slice_s),
    .cout (slice_cout),
    .cmsb (slice_cmsb)
  );

  // Result fills from the top so the first (least significant) slice ends up at bit 0.
  assign res_shift  = (WIDTH'(slice_s) << (WIDTH - BITS_PER_CYC)) | (res_reg >> BITS_PER_CYC);
  assign last_slice = (count_reg == CW'(N - 1));
  assign in_ready   = (state_reg == IDLE) && ena;

`ifdef SERIAL_ADDER_SAT_EN
  logic sub_reg;

  always_comb begin
    final_sum = res_shift;
    if (!sub_reg && slice_cout) begin
      final_sum = '1;
    end else if (sub_reg && !slice_cout) begin
      final_sum = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_reg <= 1'b0;
    end else if (ena && in_valid && state_reg == IDLE) begin
      sub_reg <= sub;
    end
  end
`else
  assign final_sum = res_shift;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      count_reg <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else if (ena) begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b ^ {WIDTH{sub}};
            carry_reg <= sub;
            count_reg <= '0;
            state_reg <= CALC;
          end
        end
        CALC: begin
          res_reg   <= res_shift;
          a_reg     <= a_reg >> BITS_PER_CYC;
          b_reg     <= b_reg >> BITS_PER_CYC;
          carry_reg <= slice_cout;
          count_reg <= count_reg + 1'b1;
          if (last_slice) begin
            sum       <= final_sum;
            carry_out <= slice_cout;
            overflow  <= slice_cmsb ^ slice_cout;
            out_valid <= 1'b1;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: directed and random operations on 8-bit instances with 1 and 4 bits per cycle.
`timescale 1ns/1ps
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] a, b;
  logic       sub;

  logic       ena1, in_valid1, out_ready1;
  logic       in_ready1, out_valid1, carry_out1, overflow1;
  logic [7:0] sum1;
  logic       ena4, in_valid4, out_ready4;
  logic       in_ready4, out_valid4, carry_out4, overflow4;
  logic [7:0] sum4;

  int vectors = 0;
  int miscompares = 0;

  serial_adder #(.WIDTH(8), .BITS_PER_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .carry_out(carry_out1), .overflow(overflow1)
  );

  serial_adder #(.WIDTH(8), .BITS_PER_CYC(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena4), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .carry_out(carry_out4), .overflow(overflow4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    int ur, sr;
    logic [7:0] res;
    logic co, ov;
    if (s) begin
      ur = int'(x) - int'(y);
      sr = int'($signed(x)) - int'($signed(y));
      co = (x >= y);
    end else begin
      ur = int'(x) + int'(y);
      sr = int'($signed(x)) + int'($signed(y));
      co = (ur > 255);
    end
    res = ur[7:0];
    ov  = (sr > 127) || (sr < -128);
`ifdef SERIAL_ADDER_SAT_EN
    if (!s && co) res = 8'hFF;
    if (s && !co) res = 8'h00;
`endif
    return {co, ov, res};
  endfunction

  function automatic logic sel_ov(input int sel);
    return (sel == 1) ? out_valid1 : out_valid4;
  endfunction

  // Runs one operation on the selected instance and checks result, flags and latency.
  task automatic run_op(input int sel, input logic [7:0] xa, input logic [7:0] xb,
                        input logic xs, input int gap, input string tag);
    int cnt;
    int n;
    logic [9:0] exp;
    n   = (sel == 1) ? 8 : 2;
    exp = model(xa, xb, xs);
    @(negedge clk);
    a = xa; b = xb; sub = xs;
    check({tag, ".in_ready"}, (sel == 1) ? in_ready1 : in_ready4, 1'b1);
    if (sel == 1) in_valid1 = 1'b1; else in_valid4 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    a = $urandom; b = $urandom; sub = $urandom;
    if (gap > 0) begin
      if (sel == 1) ena1 = 1'b0; else ena4 = 1'b0;
    end
    cnt = 0;
    while (!sel_ov(sel) && cnt < 60) begin
      @(negedge clk);
      cnt++;
      if (cnt == gap) begin
        ena1 = 1'b1; ena4 = 1'b1;
      end
    end
    check({tag, ".latency"}, cnt, n + gap);
    check({tag, ".sum"}, (sel == 1) ? sum1 : sum4, exp[7:0]);
    check({tag, ".carry"}, (sel == 1) ? carry_out1 : carry_out4, exp[9]);
    check({tag, ".ovf"}, (sel == 1) ? overflow1 : overflow4, exp[8]);
    if (sel == 1) out_ready1 = 1'b1; else out_ready4 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0; out_ready4 = 1'b0;
    check({tag, ".valid_drop"}, sel_ov(sel), 1'b0);
    check({tag, ".ready_back"}, (sel == 1) ? in_ready1 : in_ready4, 1'b1);
  endtask

  initial begin
    logic [7:0] held;
    logic [9:0] exp;
    int cnt;

    rst_n = 1'b0;
    ena1 = 1'b1; ena4 = 1'b1;
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    out_ready1 = 1'b0; out_ready4 = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.out_valid", out_valid1, 1'b0);
    check("rst.sum", sum1, 8'h00);
    check("rst.carry", carry_out1, 1'b0);
    check("rst.ovf", overflow1, 1'b0);
    rst_n = 1'b1;

    // Directed vectors
    run_op(1, 8'h5A, 8'h33, 1'b0, 0, "add_5a_33");
    run_op(1, 8'hFF, 8'h01, 1'b0, 0, "add_ff_01");
    run_op(1, 8'h10, 8'h20, 1'b1, 0, "sub_10_20");
    run_op(4, 8'h7F, 8'h01, 1'b0, 0, "bpc4_7f_01");
    run_op(4, 8'h7F, 8'h01, 1'b0, 3, "bpc4_ena_gap");
    run_op(1, 8'h7F, 8'h01, 1'b0, 2, "bpc1_ena_gap");

    // Back-pressure: result must hold while out_ready is low
    @(negedge clk);
    a = 8'hC3; b = 8'h5E; sub = 1'b1; in_valid1 = 1'b1;
    exp = model(8'hC3, 8'h5E, 1'b1);
    @(negedge clk);
    in_valid1 = 1'b0;
    cnt = 0;
    while (!out_valid1 && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    check("hold.latency", cnt, 8);
    held = sum1;
    check("hold.sum", held, exp[7:0]);
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; in_valid1 = 1'b1;
      check("hold.in_ready", in_ready1, 1'b0);
      @(negedge clk);
      in_valid1 = 1'b0;
      check("hold.stable", sum1, held);
      check("hold.valid", out_valid1, 1'b1);
    end
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check("hold.release_valid", out_valid1, 1'b0);
    check("hold.release_ready", in_ready1, 1'b1);
    @(negedge clk);
    check("hold.no_spurious", out_valid1, 1'b0);

    // Reset mid-CALC aborts with no partial result flagged
    a = 8'h99; b = 8'h77; sub = 1'b0; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.valid", out_valid1, 1'b0);
    check("abort.sum", sum1, 8'h00);
    check("abort.carry", carry_out1, 1'b0);
    check("abort.ovf", overflow1, 1'b0);
    check("abort.idle", in_ready1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1, 8'h01, 8'h01, 1'b0, 0, "post_abort");

    // Random operations against the reference model
    for (int i = 0; i < 20; i++) begin
      run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 0, $sformatf("rnd1_%0d", i));
    end
    for (int i = 0; i < 12; i++) begin
      run_op(4, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
             $sformatf("rnd4_%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, handshaked, multi-cycle adder/subtractor; successor to the team's single-bit combinational half adder.
- Processes BITS_PER_CYC operand bits per clock through a ripple slice; produces sum, carry-out and signed overflow.
- Sits behind the tt_um top wrapper: ui_in/uio_in feed the operands, uo_out carries the result.

Parameters:
- WIDTH, 8: operand/result width in bits; legal range 2..32.
- BITS_PER_CYC, 1: bits processed per CALC cycle; must divide WIDTH (elaboration error otherwise).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  design enable; low freezes all state.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A-B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- carry_out  out  1  add: unsigned carry; sub: 1 = no borrow (A>=B unsigned).
- overflow  out  1  signed two's-complement overflow.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, named rst_n.
- Reset: state=IDLE; sum, carry_out, overflow, out_valid = 0; internal count and shift registers = 0.
- States: IDLE, CALC, HOLD.
- in_ready = (state==IDLE) && ena, combinational.
- IDLE -> CALC on a clock edge with in_valid && in_ready.
  - Latch a; latch b XOR {WIDTH{sub}}; carry register = sub; count = 0.
- CALC, per cycle:
  - Add the low BITS_PER_CYC bits of the A and B registers plus the carry register.
  - Shift the slice result into the top of the result register; shift A and B right by BITS_PER_CYC.
  - Update the carry register; count++.
  - On the last slice, also capture carry-in-to-MSB XOR carry-out-of-MSB as overflow.
- After N = WIDTH/BITS_PER_CYC CALC cycles -> HOLD.
  - sum, carry_out and overflow are registered; out_valid = 1.
  - Latency: out_valid rises N edges after the accepting edge (ena held high).
- HOLD -> IDLE on out_ready && ena.
  - out_valid drops that edge; sum, carry_out and overflow hold their last values until the next HOLD.
- No overlap: a new operation is accepted only from IDLE, so in_ready = 0 during CALC and HOLD.
- Outputs are stable while out_valid=1 && !out_ready; operand inputs are don't-care outside the accept edge.
- ena low: no register changes in any state; in_ready = 0; out_valid retains its value.
- Reset mid-CALC or mid-HOLD: immediate abort to the reset values; no partial result is ever flagged valid.
- Arithmetic: result is modulo 2^WIDTH; the carry chain is exactly WIDTH bits.

Optional Feature:
- Macro: SERIAL_ADDER_SAT_EN.
- Defined: sum saturates.
  - Add with carry_out=1 gives sum = all ones.
  - Sub with carry_out=0 (borrow) gives sum = 0.
  - carry_out and overflow still report the raw unsaturated result.
  - Clamping is applied in the CALC->HOLD transition, so latency is unchanged.
- Undefined: sum wraps modulo 2^WIDTH; no extra logic.

Decomposition:
- Package serial_adder_pkg holds:
  - the state enum typedef (IDLE, CALC, HOLD);
  - a localparam function for N and the count width, $clog2(N+1).
- One sub-module, adder_slice: combinational BITS_PER_CYC-bit ripple full adder.
  - Inputs: a, b, cin.
  - Outputs: s, cout, and the carry into the slice MSB (feeds overflow).
- The FSM, counter and shift registers live in serial_adder.

Test Plan:
- WIDTH=8, BPC=1; a=0x5A, b=0x33, sub=0 -> after 8 cycles sum=0x8D, carry_out=0, overflow=1.
- a=0xFF, b=0x01, sub=0 -> sum=0x00, carry_out=1, overflow=0; with SERIAL_ADDER_SAT_EN, sum=0xFF.
- a=0x10, b=0x20, sub=1 -> sum=0xF0, carry_out=0, overflow=0; with SERIAL_ADDER_SAT_EN, sum=0x00.
- Hold out_ready=0 for 5 cycles after out_valid -> sum stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge, in_ready=1.
- Deassert rst_n at CALC cycle 3 -> all outputs 0 at once, state IDLE; the next operation 0x01+0x01 gives 0x02.
- WIDTH=8, BPC=4; a=0x7F, b=0x01 -> out_valid 2 edges after accept, sum=0x80, overflow=1. Drop ena for 3 cycles mid-CALC -> latency extends by exactly 3, same result.
